// File: rtl/memaccess_pkg.sv
// Shared widths, memory-op codes and memory-access stage state encodings.
// Imported by the memaccess stage and by anything that drives it.
package memaccess_pkg;

    localparam int WORD  = 32;
    localparam int ADDR  = 16;
    localparam int W_RD  = 5;
    localparam int W_MOP = 2;

    typedef enum logic [W_MOP-1:0] {
        MOP_NONE  = 2'd0,
        MOP_LOAD  = 2'd1,
        MOP_STORE = 2'd2,
        MOP_RSVD  = 2'd3
    } mop_e;

    typedef enum logic [1:0] {
        MA_EMPTY  = 2'd0,
        MA_FULL   = 2'd1,
        MA_LDWAIT = 2'd2
    } ma_state_e;

    // Registered output entry handed to writeback.
    typedef struct packed {
        logic            v;
        logic            wb;
        logic [W_RD-1:0] rd_num;
        logic [WORD-1:0] rd_data;
    } ma_out_t;

    localparam ma_out_t MA_OUT_RESET = '{v: 1'b0, wb: 1'b0, rd_num: '0, rd_data: '0};

endpackage

// File: rtl/memaccess.sv
// Memory-access pipeline stage: issues loads/stores to the external synchronous
// data memory and passes ALU results through, with valid/stall on both sides.
module memaccess
    import memaccess_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             v_i,
    output logic             stall_o,
    input  logic [W_MOP-1:0] mop_i,
    input  logic [ADDR-1:0]  addr_i,
    input  logic [WORD-1:0]  st_data_i,
    input  logic             wb_i,
    input  logic [W_RD-1:0]  rd_num_i,
    input  logic [WORD-1:0]  rd_data_i,
    input  logic             stall_i,
    output logic             v_o,
    output logic             wb_o,
    output logic [W_RD-1:0]  rd_num_o,
    output logic [WORD-1:0]  rd_data_o,
    output logic [ADDR-1:0]  mem_a_o,
    output logic             mem_w_o,
    output logic [WORD-1:0]  mem_d_o,
    input  logic [WORD-1:0]  mem_q_i
);

    ma_state_e state_q, state_d;
    ma_out_t   out_q, out_d;
    logic      accept;

    // Handshake and memory drive are purely combinational so a store lands
    // at the same edge the entry is accepted.
    always_comb begin
        stall_o = (state_q == MA_LDWAIT) || ((state_q == MA_FULL) && stall_i);
        accept  = v_i && !stall_o;
        mem_a_o = addr_i;
        mem_d_o = st_data_i;
        mem_w_o = accept && (mop_i == MOP_STORE) && !rst;
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // through the case below can leave a latch behind.
        state_d = state_q;
        out_d   = out_q;

        unique case (state_q)
            MA_EMPTY, MA_FULL: begin
                if ((state_q == MA_FULL) && stall_i) begin
                    state_d = MA_FULL;
                end else if (accept) begin
                    out_d.rd_num = rd_num_i;
                    case (mop_i)
                        MOP_LOAD: begin
                            state_d  = MA_LDWAIT;
                            out_d.v  = 1'b0;
                            out_d.wb = wb_i;
                        end
                        MOP_STORE: begin
                            state_d       = MA_FULL;
                            out_d.v       = 1'b1;
                            out_d.wb      = 1'b0;
                            out_d.rd_data = st_data_i;
                        end
                        default: begin
                            // Reserved code behaves as a plain pass-through.
                            state_d       = MA_FULL;
                            out_d.v       = 1'b1;
                            out_d.wb      = wb_i;
                            out_d.rd_data = rd_data_i;
                        end
                    endcase
                end else begin
                    state_d = MA_EMPTY;
                    out_d.v = 1'b0;
                end
            end
            MA_LDWAIT: begin
                // Load data is captured regardless of downstream stall.
                state_d       = MA_FULL;
                out_d.v       = 1'b1;
                out_d.rd_data = mem_q_i;
            end
            default: begin
                state_d = MA_EMPTY;
                out_d   = MA_OUT_RESET;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MA_EMPTY;
            out_q   <= MA_OUT_RESET;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign v_o       = out_q.v;
    assign wb_o      = out_q.wb;
    assign rd_num_o  = out_q.rd_num;
    assign rd_data_o = out_q.rd_data;

endmodule

// File: doc/memaccess.md
Name: memaccess

Overview:
- Memory-access stage between execute and writeback.
- Executes loads and stores against the word-addressed data memory, a synchronous single-port 32x64k instance in core.
- Passes ALU results through unchanged for non-memory ops.
- Uses the pipeline's valid/stall handshake on both sides.

Parameters:
- WORD, 32, data width.
- ADDR, 16, word-address width of the data memory.
- W_RD, 5, register-number width.
- W_MOP, 2, memory-op code width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- v_i  in  1  upstream (EX) entry valid
- stall_o  out  1  upstream must hold its entry
- mop_i  in  W_MOP  memory op: NONE/LOAD/STORE
- addr_i  in  ADDR  memory word address (from EX result)
- st_data_i  in  WORD  store data
- wb_i  in  1  entry writes a register
- rd_num_i  in  W_RD  destination register
- rd_data_i  in  WORD  ALU result for non-memory ops
- stall_i  in  1  downstream (WB) cannot accept
- v_o  out  1  output entry valid
- wb_o  out  1  writeback enable to WB
- rd_num_o  out  W_RD  destination register to WB
- rd_data_o  out  WORD  result to WB (ALU or load data)
- mem_a_o  out  ADDR  data-memory address
- mem_w_o  out  1  data-memory write enable
- mem_d_o  out  WORD  data-memory write data
- mem_q_i  in  WORD  data-memory read data, valid the cycle after the address edge

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: state=EMPTY, v_o=0, wb_o=0, rd_num_o=0, rd_data_o=0. While rst=1, mem_w_o is forced to 0.
- States:
  - EMPTY: no entry held.
  - FULL: output entry valid.
  - LDWAIT: load address issued, data due this cycle.
- Accept rule: accept = v_i && !stall_o. stall_o = (state==LDWAIT) || (state==FULL && stall_i). In EMPTY, stall_o=0.
- Memory drive (combinational):
  - mem_a_o = addr_i; mem_d_o = st_data_i.
  - mem_w_o = accept && mop_i==STORE && !rst.
  - A store writes only on an accepted cycle.
- Op on accept:
  - NONE: next state FULL; v_o=1, wb_o=wb_i, rd_num_o=rd_num_i, rd_data_o=rd_data_i. Latency 1.
  - STORE: memory written at that edge. Next state FULL with wb_o=0, rd_data_o=st_data_i (don't-care for WB). Latency 1.
  - LOAD: next state LDWAIT with v_o=0; wb_o and rd_num_o latched. In LDWAIT, rd_data_o<=mem_q_i, v_o<=1, next state FULL. Latency 2; costs one bubble.
  - Reserved code 3: treated as NONE.
- FULL with stall_i=1: all outputs hold.
- FULL with stall_i=0 and no accept: next state EMPTY, v_o=0.
- FULL with stall_i=0 and accept: back-to-back; new entry replaces old at the same edge. Sustained throughput is 1/cycle for non-load ops.
- LDWAIT ignores stall_i: data is captured unconditionally into the output register. Upstream is stalled that cycle.
- Hazard (load then store to same address, back-to-back): the load is in LDWAIT, so the store is stalled one cycle. No read/write collision.
- Reset mid-operation (asserted in LDWAIT or FULL): state goes to EMPTY and all outputs to reset values immediately. Pending load data is discarded. No memory write occurs while rst=1.
- Outputs v_o, wb_o, rd_num_o, rd_data_o are registered. stall_o and mem_* are combinational.

Decomposition:
- Shared params.vh gains: W_MOP; MOP_NONE=2'd0, MOP_LOAD=2'd1, MOP_STORE=2'd2; memaccess state encodings MA_EMPTY/MA_FULL/MA_LDWAIT.
- No sub-module. A single FSM plus output register fits one module.
- The data-memory instance (DP_mem32x64k) lives in core, not inside memaccess.

Test Plan:
- Reset, then NONE op: wb_i=1, rd_num_i=3, rd_data_i=32'hDEAD_BEEF, stall_i=0 -> next cycle v_o=1, wb_o=1, rd_num_o=3, rd_data_o=DEAD_BEEF; mem_w_o never 1.
- STORE addr=16'h0040, data=32'h1234_5678, then LOAD addr=16'h0040 rd_num=7 -> store cycle: mem_w_o=1 for exactly one cycle. Load: stall_o=1 during LDWAIT; v_o=1 two cycles after load accept with rd_data_o=1234_5678, wb_o=1, rd_num_o=7.
- Back-to-back NONE ops A,B,C with stall_i=0 -> v_o high three consecutive cycles, outputs A,B,C in order, stall_o=0 throughout.
- FULL with stall_i=1 for 3 cycles and v_i=1 holding entry X -> outputs frozen, stall_o=1, X not accepted. After stall_i drops, X appears the next cycle; no duplicate or lost entry.
- STORE presented with v_i=1 while stall_o=1 -> mem_w_o=0, memory contents unchanged (read back the old value with a later load).
- rst asserted mid-cycle while in LDWAIT -> v_o, wb_o, rd_num_o, rd_data_o go to 0 asynchronously. After release, state is EMPTY, stall_o=0, and no stale load result is emitted.
